// File: rtl/tcache_rsp_serializer.sv
// Splits one wide texture-cache response into NUM_LANES-wide beats, optionally
// skipping batches whose mask slice is empty; accepts the next response on the last beat.
module tcache_rsp_serializer #(
  parameter int NUM_REQS   = 4,
  parameter int NUM_LANES  = 2,
  parameter int WORD_SIZE  = 4,
  parameter int TAG_WIDTH  = 8,
  parameter int SKIP_EMPTY = 1,
  localparam int WORD_WIDTH  = 8 * WORD_SIZE,
  localparam int NUM_BATCHES = NUM_REQS / NUM_LANES,
  localparam int PID_W       = (NUM_BATCHES > 1) ? $clog2(NUM_BATCHES) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             rsp_in_valid,
  input  logic [NUM_REQS-1:0]              rsp_in_tmask,
  input  logic [NUM_REQS*WORD_WIDTH-1:0]   rsp_in_data,
  input  logic [TAG_WIDTH-1:0]             rsp_in_tag,
  output logic                             rsp_in_ready,
  output logic                             rsp_out_valid,
  output logic [NUM_LANES-1:0]             rsp_out_tmask,
  output logic [NUM_LANES*WORD_WIDTH-1:0]  rsp_out_data,
  output logic [TAG_WIDTH-1:0]             rsp_out_tag,
  output logic [PID_W-1:0]                 rsp_out_pid,
  output logic                             rsp_out_eop,
  input  logic                             rsp_out_ready
);

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_e;

  state_e                          state_q, state_d;
  logic [PID_W-1:0]                pid_q, pid_d;
  logic [NUM_REQS-1:0]             tmask_q;
  logic [NUM_REQS*WORD_WIDTH-1:0]  data_q;
  logic [TAG_WIDTH-1:0]            tag_q;

  logic             in_fire, out_fire;
  logic             has_next;
  logic [PID_W-1:0] next_pid, first_pid;

  function automatic logic batch_live(input logic [NUM_REQS-1:0] m, input int b);
    return (SKIP_EMPTY == 0) || (m[b*NUM_LANES +: NUM_LANES] != '0);
  endfunction

  assign in_fire  = rsp_in_valid && rsp_in_ready;
  assign out_fire = rsp_out_valid && rsp_out_ready;

  // Descending scans so the lowest qualifying batch index wins; an all-empty
  // response falls back to batch 0 so its tag is still returned.
  always_comb begin
    has_next  = 1'b0;
    next_pid  = '0;
    first_pid = '0;
    for (int b = NUM_BATCHES - 1; b >= 0; b--) begin
      if ((PID_W'(b) > pid_q) && batch_live(tmask_q, b)) begin
        has_next = 1'b1;
        next_pid = PID_W'(b);
      end
      if (batch_live(rsp_in_tmask, b)) begin
        first_pid = PID_W'(b);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pid_q   <= '0;
    end else begin
      state_q <= state_d;
      pid_q   <= pid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      tmask_q <= rsp_in_tmask;
      data_q  <= rsp_in_data;
      tag_q   <= rsp_in_tag;
    end
  end

  always_comb begin
    state_d = state_q;
    pid_d   = pid_q;
    case (state_q)
      IDLE: begin
        if (in_fire) begin
          state_d = SEND;
          pid_d   = first_pid;
        end
      end
      SEND: begin
        if (out_fire) begin
          if (has_next) begin
            pid_d = next_pid;
          end else if (in_fire) begin
            pid_d = first_pid;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rsp_out_valid = (state_q == SEND);
    rsp_out_eop   = (state_q == SEND) && !has_next;
    rsp_in_ready  = (state_q == IDLE) || (rsp_out_ready && !has_next);
  end

  always_comb begin
    rsp_out_tmask = '0;
    rsp_out_data  = '0;
    for (int b = 0; b < NUM_BATCHES; b++) begin
      if (pid_q == PID_W'(b)) begin
        rsp_out_tmask = tmask_q[b*NUM_LANES +: NUM_LANES];
        rsp_out_data  = data_q[b*NUM_LANES*WORD_WIDTH +: NUM_LANES*WORD_WIDTH];
      end
    end
  end

  assign rsp_out_tag = tag_q;
  assign rsp_out_pid = pid_q;

endmodule

// File: tb/tb_tcache_rsp_serializer.sv
// Bench for tcache_rsp_serializer: one instance per SKIP_EMPTY setting, shared stimulus,
// expected beats from a list-based model of batch selection.
module tb_tcache_rsp_serializer;

  typedef struct packed {
    logic [3:0]   m;
    logic [127:0] d;
    logic [7:0]   t;
  } rsp_t;

  typedef struct packed {
    logic [1:0]  m;
    logic [63:0] d;
    logic [7:0]  t;
    logic        pid;
    logic        eop;
  } beat_t;

  logic         clk;
  logic         reset;
  logic         valid_c;
  logic [3:0]   tmask_c;
  logic [127:0] data_c;
  logic [7:0]   tag_c;
  logic         out_ready;
  logic         sel;

  logic        iv [2];
  logic        ir [2];
  logic        ov [2];
  logic [1:0]  om [2];
  logic [63:0] od [2];
  logic [7:0]  ot [2];
  logic [0:0]  op [2];
  logic        oe [2];

  logic        s_ov, s_ir, s_eop;
  logic [1:0]  s_om;
  logic [63:0] s_od;
  logic [7:0]  s_ot;
  logic [0:0]  s_op;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign iv[g] = valid_c && (sel == 1'(g));
    tcache_rsp_serializer #(
      .NUM_REQS(4), .NUM_LANES(2), .WORD_SIZE(4), .TAG_WIDTH(8), .SKIP_EMPTY(g)
    ) u_dut (
      .clk(clk), .reset(reset),
      .rsp_in_valid(iv[g]), .rsp_in_tmask(tmask_c), .rsp_in_data(data_c),
      .rsp_in_tag(tag_c), .rsp_in_ready(ir[g]),
      .rsp_out_valid(ov[g]), .rsp_out_tmask(om[g]), .rsp_out_data(od[g]),
      .rsp_out_tag(ot[g]), .rsp_out_pid(op[g]), .rsp_out_eop(oe[g]),
      .rsp_out_ready(out_ready)
    );
  end

  assign s_ov  = ov[sel];
  assign s_ir  = ir[sel];
  assign s_om  = om[sel];
  assign s_od  = od[sel];
  assign s_ot  = ot[sel];
  assign s_op  = op[sel];
  assign s_eop = oe[sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  rsp_t  pend[$];
  beat_t got[$];
  int    got_cyc[$];
  bit    vld_log[$];
  bit    rdy_log[$];
  bit    eop_log[$];
  beat_t exp_q[$];
  int    stall_pct = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: list the batches that will be emitted, then turn them into beats.
  function automatic void model_push(input rsp_t r, input bit skip);
    int    bl[$];
    beat_t e;
    for (int b = 0; b < 2; b++)
      if (!skip || r.m[b*2 +: 2] != 2'b00) bl.push_back(b);
    if (bl.size() == 0) bl.push_back(0);
    foreach (bl[k]) begin
      e.m   = r.m[bl[k]*2 +: 2];
      e.d   = r.d[bl[k]*64 +: 64];
      e.t   = r.t;
      e.pid = 1'(bl[k]);
      e.eop = (k == bl.size() - 1);
      exp_q.push_back(e);
    end
  endfunction

  // Offers every queued response back-to-back and records accepted beats.
  task automatic collect(input int max_cyc);
    int cyc = 0;
    bit done = 0;
    bit acc;
    beat_t bt;
    got.delete(); got_cyc.delete(); vld_log.delete(); rdy_log.delete(); eop_log.delete();
    while (!done) begin
      valid_c = (pend.size() > 0);
      if (pend.size() > 0) begin
        tmask_c = pend[0].m;
        data_c  = pend[0].d;
        tag_c   = pend[0].t;
      end
      out_ready = ($urandom_range(99) >= stall_pct);
      #1;
      vld_log.push_back(s_ov);
      rdy_log.push_back(s_ir);
      eop_log.push_back(s_eop);
      if (s_ov && out_ready) begin
        bt = {s_om, s_od, s_ot, s_op, s_eop};
        got.push_back(bt);
        got_cyc.push_back(cyc);
      end
      acc = valid_c && s_ir;
      if (acc) void'(pend.pop_front());
      if (pend.size() == 0 && !acc && !(s_ov && !(out_ready && s_eop))) done = 1;
      cyc++;
      if (!done && cyc >= max_cyc) begin
        n_cmp++; n_bad++;
        $display("FAIL collect_timeout: still busy after %0d cycles, required idle", cyc);
        done = 1;
      end
      tick();
    end
    valid_c   = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (ov[k] !== 1'b0) begin n_bad++; $display("FAIL reset_valid%0d: got %b want 0", k, ov[k]); end
      n_cmp++;
      if (ir[k] !== 1'b1) begin n_bad++; $display("FAIL reset_ready%0d: got %b want 1", k, ir[k]); end
      n_cmp++;
      if (op[k] !== 1'b0) begin n_bad++; $display("FAIL reset_pid%0d: got %b want 0", k, op[k]); end
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    beat_t want[2];
    sel = 1'b0;
    stall_pct = 0;
    want[0] = {2'b11, 64'h00000011_00000000, 8'h5A, 1'b0, 1'b0};
    want[1] = {2'b11, 64'h00000033_00000022, 8'h5A, 1'b1, 1'b1};
    pend.push_back({4'b1111, {32'h33, 32'h22, 32'h11, 32'h00}, 8'h5A});
    collect(20);
    n_cmp++;
    if (got.size() != 2) begin n_bad++; $display("FAIL basic_count: got %0d want 2", got.size()); end
    for (int i = 0; i < got.size() && i < 2; i++) begin
      n_cmp++;
      if (got[i] !== want[i]) begin n_bad++; $display("FAIL basic_beat%0d: got %h want %h", i, got[i], want[i]); end
      n_cmp++;
      if (got_cyc[i] != i + 1) begin n_bad++; $display("FAIL basic_latency%0d: got cycle %0d want %0d", i, got_cyc[i], i + 1); end
    end
  endtask

  task automatic test_skip();
    rsp_t  r;
    beat_t w1, w0a, w0b;
    r = {4'b1100, {$urandom, $urandom, $urandom, $urandom}, 8'hC3};
    w1  = {2'b11, r.d[127:64], 8'hC3, 1'b1, 1'b1};
    w0a = {2'b00, r.d[63:0],   8'hC3, 1'b0, 1'b0};
    w0b = {2'b11, r.d[127:64], 8'hC3, 1'b1, 1'b1};
    sel = 1'b1;
    pend.push_back(r);
    collect(20);
    n_cmp++;
    if (got.size() != 1) begin n_bad++; $display("FAIL skip1_count: got %0d want 1", got.size()); end
    else begin
      n_cmp++;
      if (got[0] !== w1) begin n_bad++; $display("FAIL skip1_beat: got %h want %h", got[0], w1); end
    end
    sel = 1'b0;
    pend.push_back(r);
    collect(20);
    n_cmp++;
    if (got.size() != 2) begin n_bad++; $display("FAIL skip0_count: got %0d want 2", got.size()); end
    else begin
      n_cmp++;
      if (got[0] !== w0a) begin n_bad++; $display("FAIL skip0_beat0: got %h want %h", got[0], w0a); end
      n_cmp++;
      if (got[1] !== w0b) begin n_bad++; $display("FAIL skip0_beat1: got %h want %h", got[1], w0b); end
    end
  endtask

  task automatic test_empty();
    rsp_t  r;
    beat_t w;
    r = {4'b0000, {$urandom, $urandom, $urandom, $urandom}, 8'h07};
    w = {2'b00, r.d[63:0], 8'h07, 1'b0, 1'b1};
    sel = 1'b1;
    pend.push_back(r);
    collect(20);
    n_cmp++;
    if (got.size() != 1) begin n_bad++; $display("FAIL empty_count: got %0d want 1", got.size()); end
    else begin
      n_cmp++;
      if (got[0] !== w) begin n_bad++; $display("FAIL empty_beat: got %h want %h", got[0], w); end
    end
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    for (int t = 1; t <= 3; t++)
      pend.push_back({4'b1111, {$urandom, $urandom, $urandom, $urandom}, 8'(t)});
    collect(40);
    n_cmp++;
    if (got.size() != 6) begin n_bad++; $display("FAIL b2b_count: got %0d want 6", got.size()); end
    for (int i = 0; i < got.size() && i < 6; i++) begin
      n_cmp++;
      if (got_cyc[i] != got_cyc[0] + i || got[i].t != 8'(i / 2 + 1)) begin
        n_bad++;
        $display("FAIL b2b_beat%0d: got cycle %0d tag %h want cycle %0d tag %h",
                 i, got_cyc[i], got[i].t, got_cyc[0] + i, 8'(i / 2 + 1));
      end
    end
    foreach (vld_log[c]) begin
      if (vld_log[c]) begin
        n_cmp++;
        if (rdy_log[c] !== eop_log[c]) begin
          n_bad++;
          $display("FAIL b2b_ready_c%0d: in_ready %b want %b (eop)", c, rdy_log[c], eop_log[c]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    rsp_t r;
    r = {4'b1011, {$urandom, $urandom, $urandom, $urandom}, 8'h9E};
    sel = 1'b0;
    tmask_c = r.m; data_c = r.d; tag_c = r.t;
    valid_c = 1'b1;
    out_ready = 1'b0;
    tick();
    valid_c = 1'b0;
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if ({s_ov, s_ir, s_op, s_om, s_od, s_ot, s_eop} !== {1'b1, 1'b0, 1'b0, r.m[1:0], r.d[63:0], r.t, 1'b0}) begin
        n_bad++;
        $display("FAIL bp_hold%0d: got v%b r%b p%b m%b d%h t%h e%b want v1 r0 p0 m%b d%h t%h e0",
                 c, s_ov, s_ir, s_op, s_om, s_od, s_ot, s_eop, r.m[1:0], r.d[63:0], r.t);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if ({s_ov, s_op, s_ir} !== 3'b100) begin n_bad++; $display("FAIL bp_resume0: got v%b p%b r%b want v1 p0 r0", s_ov, s_op, s_ir); end
    tick();
    n_cmp++;
    if ({s_ov, s_op, s_eop, s_ir, s_om, s_od} !== {4'b1111, r.m[3:2], r.d[127:64]}) begin
      n_bad++;
      $display("FAIL bp_resume1: got v%b p%b e%b r%b m%b d%h want v1 p1 e1 r1 m%b d%h",
               s_ov, s_op, s_eop, s_ir, s_om, s_od, r.m[3:2], r.d[127:64]);
    end
    tick();
    n_cmp++;
    if (s_ov !== 1'b0) begin n_bad++; $display("FAIL bp_drain: valid %b want 0", s_ov); end
  endtask

  task automatic test_reset_mid();
    sel = 1'b1;
    tmask_c = 4'b1111; data_c = {$urandom, $urandom, $urandom, $urandom}; tag_c = 8'h44;
    valid_c = 1'b1;
    out_ready = 1'b1;
    tick();
    valid_c = 1'b0;
    tick();
    out_ready = 1'b0;
    #1;
    n_cmp++;
    if ({s_ov, s_op} !== 2'b11) begin n_bad++; $display("FAIL rst_mid_pending: got v%b p%b want v1 p1", s_ov, s_op); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    n_cmp++;
    if ({s_ov, s_ir, s_op} !== 3'b010) begin
      n_bad++;
      $display("FAIL rst_mid_after: got v%b r%b p%b want v0 r1 p0", s_ov, s_ir, s_op);
    end
    pend.push_back({4'b1111, {$urandom, $urandom, $urandom, $urandom}, 8'h55});
    collect(20);
    n_cmp++;
    if (got.size() != 2 || got[0].pid !== 1'b0 || got[0].t !== 8'h55) begin
      n_bad++;
      $display("FAIL rst_mid_restart: got %0d beats, first %h want 2 beats starting pid 0 tag 55",
               got.size(), (got.size() > 0) ? got[0] : '0);
    end
  endtask

  task automatic test_random();
    rsp_t r;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      stall_pct = 35;
      exp_q.delete();
      for (int n = 0; n < 25; n++) begin
        r.m = 4'($urandom_range(15));
        if ($urandom_range(4) == 0) r.m = 4'b0000;
        r.d = {$urandom, $urandom, $urandom, $urandom};
        r.t = 8'($urandom);
        pend.push_back(r);
        model_push(r, s[0]);
      end
      collect(2000);
      n_cmp++;
      if (got.size() != exp_q.size()) begin
        n_bad++;
        $display("FAIL rand_count_s%0d: got %0d want %0d", s, got.size(), exp_q.size());
      end
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
        n_cmp++;
        if (got[i] !== exp_q[i]) begin
          n_bad++;
          $display("FAIL rand_beat_s%0d_%0d: got %h want %h", s, i, got[i], exp_q[i]);
        end
      end
    end
    stall_pct = 0;
  endtask

  initial begin
    reset = 1'b1;
    valid_c = 1'b0;
    tmask_c = '0;
    data_c = '0;
    tag_c = '0;
    out_ready = 1'b1;
    sel = 1'b0;
    test_reset();
    test_basic();
    test_skip();
    test_empty();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule

// File: doc/tcache_rsp_serializer.md
Name: tcache_rsp_serializer

Overview:
- Sits between the texture cache response port and the texture unit writeback.
- Accepts one wide response per handshake (NUM_REQS words, thread mask, tag) and re-issues it as one or more narrow beats of NUM_LANES words.
- Optionally skips batches whose mask bits are all zero.
- Full-throughput buffering: a new response is accepted in the same cycle the last beat of the previous one drains.

Parameters:
- NUM_REQS, 4: words per input response; must be a multiple of NUM_LANES.
- NUM_LANES, 2: words per output beat; NUM_BATCHES = NUM_REQS/NUM_LANES.
- WORD_SIZE, 4: bytes per word; WORD_WIDTH = 8*WORD_SIZE.
- TAG_WIDTH, 8: response tag width.
- SKIP_EMPTY, 1: 1 = omit batches with zero mask bits; 0 = emit every batch.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- rsp_in_valid  in  1  wide response valid
- rsp_in_tmask  in  NUM_REQS  per-word valid mask
- rsp_in_data  in  NUM_REQS*WORD_WIDTH  word i at bits [i*WORD_WIDTH +: WORD_WIDTH]
- rsp_in_tag  in  TAG_WIDTH  response tag
- rsp_in_ready  out  1  input accept
- rsp_out_valid  out  1  beat valid
- rsp_out_tmask  out  NUM_LANES  mask slice of the current batch
- rsp_out_data  out  NUM_LANES*WORD_WIDTH  data slice of the current batch
- rsp_out_tag  out  TAG_WIDTH  tag, held constant across all beats of one response
- rsp_out_pid  out  max(1,clog2(NUM_BATCHES))  batch index of the current beat
- rsp_out_eop  out  1  last beat of this response
- rsp_out_ready  in  1  downstream accept

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset: state = IDLE, rsp_out_valid = 0, rsp_in_ready = 1, pid = 0. Data, tag and mask registers are don't-care.
- Reset asserted mid-response: the buffered response is discarded; no beat issues in the cycle after reset.
- Handshakes: valid/ready. A transfer occurs when valid && ready.
  - rsp_out_valid must not depend combinationally on rsp_out_ready.
  - Payload is stable while valid && !ready.
- State IDLE:
  - rsp_in_ready = 1.
  - On input fire, capture mask, data and tag, set pid = first batch, and go to SEND.
  - First beat is visible the next cycle (latency 1).
- State SEND:
  - rsp_out_valid = 1; outputs are slice pid of the captured response.
  - rsp_out_eop = 1 when no later batch remains.
  - On output fire with eop=0: pid advances to the next batch.
  - On output fire with eop=1: go to IDLE, or stay in SEND if the input fires in the same cycle.
  - rsp_in_ready = rsp_out_ready && rsp_out_eop in SEND. This gives back-to-back throughput with no bubble.
- Batch selection:
  - SKIP_EMPTY=0: sequential 0..NUM_BATCHES-1.
  - SKIP_EMPTY=1: the first batch and each next batch are the lowest index (above the current one, for next) with a nonzero mask slice, found by priority encoder.
- All-zero mask with SKIP_EMPTY=1: exactly one beat with pid=0, tmask=0, eop=1, so the tag is still returned.
- NUM_BATCHES=1: the block degenerates to a one-entry register stage; every beat has eop=1 and pid=0.
- No tag or mask transformation; data slices pass bit-exact.

Test Plan:
- Setup: NUM_REQS=4, NUM_LANES=2, WORD_SIZE=4, TAG_WIDTH=8 unless stated.
- Basic, SKIP_EMPTY=0, tmask=4'b1111, data words {D3,D2,D1,D0}={0x33,0x22,0x11,0x00}, tag=0x5A, out_ready=1 -> at T+1 beat pid=0 data {0x11,0x00} eop=0; at T+2 beat pid=1 data {0x33,0x22} eop=1; tag=0x5A on both beats.
- Skip, SKIP_EMPTY=1, tmask=4'b1100 -> single beat pid=1, tmask=2'b11, eop=1. SKIP_EMPTY=0 with the same mask -> two beats, the first with tmask=2'b00.
- Empty mask, SKIP_EMPTY=1, tmask=0, tag=0x07 -> one beat pid=0, tmask=0, eop=1, tag=0x07.
- Back-to-back: three responses (tags 1,2,3) offered continuously with out_ready=1 -> 6 beats on 6 consecutive cycles; rsp_in_ready pulses exactly on each eop cycle.
- Backpressure: out_ready held 0 for 5 cycles during beat pid=0 -> valid, data, tag and pid stay stable; rsp_in_ready=0; resumes correctly when ready rises.
- Reset mid-response: assert reset while pid=1 is pending -> next cycle rsp_out_valid=0, rsp_in_ready=1; a new response then starts at pid=0.
